// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions for the effective-address sequencer: opcodes,
// result kinds presented to the datapath, and sequencer states.
package lc3_pkg;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int OP_W   = OP_MSB - OP_LSB + 1;
    localparam int DATA_W = 16;

    typedef enum logic [OP_W-1:0] {
        OPC_BR   = 4'b0000,
        OPC_ADD  = 4'b0001,
        OPC_LD   = 4'b0010,
        OPC_ST   = 4'b0011,
        OPC_JSR  = 4'b0100,
        OPC_AND  = 4'b0101,
        OPC_LDR  = 4'b0110,
        OPC_STR  = 4'b0111,
        OPC_RTI  = 4'b1000,
        OPC_NOT  = 4'b1001,
        OPC_LDI  = 4'b1010,
        OPC_STI  = 4'b1011,
        OPC_JMP  = 4'b1100,
        OPC_RES  = 4'b1101,
        OPC_LEA  = 4'b1110,
        OPC_TRAP = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        KIND_NONE  = 3'd0,
        KIND_IMM   = 3'd1,
        KIND_LOAD  = 3'd2,
        KIND_STORE = 3'd3,
        KIND_ADDR  = 3'd4
    } ea_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_PTR  = 2'd2,
        ST_DONE = 2'd3
    } ea_state_e;

endpackage

// File: rtl/ea_sequencer_sext.sv
// Sign-extends a W-bit instruction field to the 16-bit datapath width.
module sext_n
    import lc3_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0]      i_field,
    output logic [DATA_W-1:0] o_ext
);

    assign o_ext = {{(DATA_W - W){i_field[W-1]}}, i_field};

endmodule

// File: rtl/ea_sequencer.sv
// LC-3 operand / effective-address sequencer: decodes a held IR, forms the
// EA with a single adder, optionally dereferences a pointer, then hands off.
module ea_sequencer
    import lc3_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ir,
    input  logic        ir_valid,
    output logic        ir_ready,
    input  logic [15:0] pc,
    output logic [2:0]  base_sel,
    input  logic [15:0] base_r,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ea,
    output logic [15:0] imm,
    output logic [2:0]  kind,
    output logic        ea_valid,
    input  logic        ea_ready,
    output logic        ea_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    ea_state_e        r_state, w_next;
    logic [15:0]      r_ir, r_pc, r_ea, r_imm;
    ea_kind_e         r_kind;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;

    opcode_e          w_op;
    logic [15:0]      w_s5, w_s6, w_s9, w_s11;
    logic [15:0]      w_off, w_imm, w_sum;
    ea_kind_e         w_kind;
    logic             w_use_base, w_has_ea, w_indirect, w_timeout;

    sext_n #(.W(5))  u_sext5  (.i_field(r_ir[4:0]),  .o_ext(w_s5));
    sext_n #(.W(6))  u_sext6  (.i_field(r_ir[5:0]),  .o_ext(w_s6));
    sext_n #(.W(9))  u_sext9  (.i_field(r_ir[8:0]),  .o_ext(w_s9));
    sext_n #(.W(11)) u_sext11 (.i_field(r_ir[10:0]), .o_ext(w_s11));

    assign w_op       = opcode_e'(r_ir[OP_MSB:OP_LSB]);
    assign w_sum      = (w_use_base ? base_r : r_pc) + w_off;
    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_timeout  = (TIMEOUT_CYC != 0) && (w_cnt_next == CNT_W'(TIMEOUT_CYC));

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_kind     = KIND_NONE;
        w_imm      = '0;
        w_off      = '0;
        w_use_base = 1'b0;
        w_has_ea   = 1'b0;
        w_indirect = 1'b0;
        case (w_op)
            OPC_ADD, OPC_AND: begin
                if (r_ir[5]) begin
                    w_kind = KIND_IMM;
                    w_imm  = w_s5;
                end
            end
            OPC_LD, OPC_ST, OPC_LEA, OPC_BR: begin
                w_off    = w_s9;
                w_has_ea = 1'b1;
                w_kind   = (w_op == OPC_LD) ? KIND_LOAD :
                           (w_op == OPC_ST) ? KIND_STORE : KIND_ADDR;
            end
            OPC_LDR, OPC_STR: begin
                w_off      = w_s6;
                w_use_base = 1'b1;
                w_has_ea   = 1'b1;
                w_kind     = (w_op == OPC_LDR) ? KIND_LOAD : KIND_STORE;
            end
            OPC_LDI, OPC_STI: begin
                w_off      = w_s9;
                w_has_ea   = 1'b1;
                w_indirect = 1'b1;
                w_kind     = (w_op == OPC_LDI) ? KIND_LOAD : KIND_STORE;
            end
            OPC_JSR: begin
                // JSRR reuses the adder with a zero offset to pass BaseR through.
                w_use_base = !r_ir[11];
                w_off      = r_ir[11] ? w_s11 : '0;
                w_has_ea   = 1'b1;
                w_kind     = KIND_ADDR;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (ir_valid)              w_next = ST_CALC;
            ST_CALC:                            w_next = w_indirect ? ST_PTR : ST_DONE;
            ST_PTR:  if (mem_ack || w_timeout)  w_next = ST_DONE;
            ST_DONE: if (ea_ready)              w_next = ST_IDLE;
            default:                            w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ir_ready = (r_state == ST_IDLE);
        mem_req  = (r_state == ST_PTR);
        ea_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ir   <= '0;
            r_pc   <= '0;
            r_ea   <= '0;
            r_imm  <= '0;
            r_kind <= KIND_NONE;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ir_valid) begin
                        r_ir <= ir;
                        r_pc <= pc;
                    end
                end
                ST_CALC: begin
                    r_ea   <= w_has_ea ? w_sum : '0;
                    r_imm  <= w_imm;
                    r_kind <= w_kind;
                    r_cnt  <= '0;
                end
                ST_PTR: begin
                    r_cnt <= w_cnt_next;
                    if (mem_ack) begin
                        r_ea <= mem_rdata;
                    end else if (w_timeout) begin
                        r_ea  <= '0;
                        r_err <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ea_ready) begin
                        r_ea   <= '0;
                        r_imm  <= '0;
                        r_kind <= KIND_NONE;
                        r_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // r_ea doubles as the pointer address while in PTR.
    assign base_sel = r_ir[8:6];
    assign mem_addr = r_ea;
    assign ea       = r_ea;
    assign imm      = r_imm;
    assign kind     = r_kind;
    assign ea_err   = r_err;

endmodule

// File: tb/tb_ea_sequencer.sv
// Bench for ea_sequencer: table of direct decodes plus hand sequences for
// pointer fetch, timeout and reset in PTR; results checked via a scoreboard.
`timescale 1ns/1ps
module tb_ea_sequencer;
    import lc3_pkg::*;

    localparam int TO = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] ir, pc, base_r, mem_rdata;
    logic        ir_valid, mem_ack, ea_ready;
    logic        ir_ready, mem_req, ea_valid, ea_err;
    logic [2:0]  base_sel, kind;
    logic [15:0] mem_addr, ea, imm;

    always #5 Clk = ~Clk;

    ea_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .Clk(Clk), .Reset(Reset), .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .pc(pc), .base_sel(base_sel), .base_r(base_r), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ea(ea),
        .imm(imm), .kind(kind), .ea_valid(ea_valid), .ea_ready(ea_ready), .ea_err(ea_err)
    );

    typedef struct {
        logic [15:0] ea;
        logic [15:0] imm;
        logic [2:0]  kind;
        logic        err;
    } exp_t;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        logic [15:0] base_r;
        logic        noise;
        logic [2:0]  bsel;
        logic [15:0] ea;
        logic [15:0] imm;
        logic [2:0]  kind;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[15];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] e_ea, input logic [15:0] e_imm,
                            input logic [2:0] e_kind, input logic e_err);
        exp_t e;
        e.ea = e_ea; e.imm = e_imm; e.kind = e_kind; e.err = e_err;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, " ea_valid"}, 16'(ea_valid), 16'd1);
        check({tag, " sb_depth"}, 16'(sb_q.size()), 16'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, " ea"},     ea,         e.ea);
            check({tag, " imm"},    imm,        e.imm);
            check({tag, " kind"},   16'(kind),  16'(e.kind));
            check({tag, " ea_err"}, 16'(ea_err), 16'(e.err));
        end
    endtask

    task automatic offer(input string tag, input logic [15:0] i, input logic [15:0] p,
                         input logic [15:0] b);
        int n;
        n = 0;
        while (!ir_ready && n < 10) begin
            tick();
            n++;
        end
        check({tag, " ir_ready_idle"}, 16'(ir_ready), 16'd1);
        ir = i; pc = p; base_r = b; ir_valid = 1'b1;
        tick();
        // Scramble IR/PC after the accept edge; the DUT must use its held copy.
        ir_valid = 1'b0; ir = ~i; pc = ~p;
    endtask

    task automatic release_done(input string tag);
        check({tag, " ir_ready_done"}, 16'(ir_ready), 16'd0);
        ea_ready = 1'b1;
        tick();
        ea_ready = 1'b0;
        mem_ack  = 1'b0;
        check({tag, " ea_valid_off"}, 16'(ea_valid), 16'd0);
        check({tag, " ir_ready_back"}, 16'(ir_ready), 16'd1);
        check({tag, " ea_cleared"}, ea, 16'h0000);
        check({tag, " kind_cleared"}, 16'(kind), 16'd0);
        check({tag, " err_cleared"}, 16'(ea_err), 16'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    lat;
        logic  seen_req;
        string tag;
        tag = $sformatf("v%0d", idx);
        mem_ack = v.noise; mem_rdata = 16'hDEAD;
        offer(tag, v.ir, v.pc, v.base_r);
        push_exp(v.ea, v.imm, v.kind, 1'b0);
        check({tag, " base_sel"}, 16'(base_sel), 16'(v.bsel));
        check({tag, " ea_valid_calc"}, 16'(ea_valid), 16'd0);
        seen_req = mem_req;
        lat = 1;
        while (!ea_valid && lat < 8) begin
            tick();
            base_r = ~v.base_r;
            lat++;
            seen_req |= mem_req;
        end
        check({tag, " latency"}, 16'(lat), 16'd2);
        check({tag, " no_mem_req"}, 16'(seen_req), 16'd0);
        pop_check(tag);
        release_done(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n_req;

        //        ir        pc        base_r  noise bsel  ea        imm       kind
        vt[0]  = '{16'h25FF, 16'h3001, 16'h1111, 1'b1, 3'd7, 16'h3000, 16'h0000, KIND_LOAD};
        vt[1]  = '{16'h7E7C, 16'h1234, 16'h0002, 1'b0, 3'd1, 16'hFFFE, 16'h0000, KIND_STORE};
        vt[2]  = '{16'h1270, 16'h3000, 16'h4444, 1'b0, 3'd1, 16'h0000, 16'hFFF0, KIND_IMM};
        vt[3]  = '{16'h1242, 16'h3000, 16'h4444, 1'b0, 3'd1, 16'h0000, 16'h0000, KIND_NONE};
        vt[4]  = '{16'h5A2F, 16'h0100, 16'h0200, 1'b0, 3'd0, 16'h0000, 16'h000F, KIND_IMM};
        vt[5]  = '{16'h3E10, 16'h3000, 16'h9999, 1'b0, 3'd0, 16'h3010, 16'h0000, KIND_STORE};
        vt[6]  = '{16'hE1FE, 16'hFFFF, 16'h0000, 1'b0, 3'd7, 16'hFFFD, 16'h0000, KIND_ADDR};
        vt[7]  = '{16'h0E05, 16'hFFFE, 16'h1234, 1'b0, 3'd0, 16'h0003, 16'h0000, KIND_ADDR};
        vt[8]  = '{16'h6A9F, 16'h0000, 16'h8000, 1'b0, 3'd2, 16'h801F, 16'h0000, KIND_LOAD};
        vt[9]  = '{16'h4FFF, 16'h2000, 16'h5555, 1'b0, 3'd7, 16'h1FFF, 16'h0000, KIND_ADDR};
        vt[10] = '{16'h4080, 16'h2000, 16'hBEEF, 1'b0, 3'd2, 16'hBEEF, 16'h0000, KIND_ADDR};
        vt[11] = '{16'h927F, 16'h5555, 16'h7777, 1'b0, 3'd1, 16'h0000, 16'h0000, KIND_NONE};
        vt[12] = '{16'hF025, 16'h3000, 16'h1111, 1'b0, 3'd0, 16'h0000, 16'h0000, KIND_NONE};
        vt[13] = '{16'hD123, 16'h3000, 16'h1111, 1'b0, 3'd4, 16'h0000, 16'h0000, KIND_NONE};
        vt[14] = '{16'hC1C0, 16'h3000, 16'h2222, 1'b0, 3'd7, 16'h0000, 16'h0000, KIND_NONE};

        Reset = 1'b1; ir = '0; pc = '0; base_r = '0; ir_valid = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0; ea_ready = 1'b0;
        repeat (2) tick();
        check("rst ir_ready", 16'(ir_ready), 16'd1);
        check("rst mem_req", 16'(mem_req), 16'd0);
        check("rst ea_valid", 16'(ea_valid), 16'd0);
        check("rst ea_err", 16'(ea_err), 16'd0);
        check("rst ea", ea, 16'h0000);
        check("rst imm", imm, 16'h0000);
        check("rst kind", 16'(kind), 16'd0);
        Reset = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) run_vec(vt[i], i);

        // LDI with ack on the third PTR cycle; result then held with ea_ready low.
        offer("ldi", 16'hA002, 16'h4000, 16'h0000);
        push_exp(16'h1234, 16'h0000, KIND_LOAD, 1'b0);
        check("ldi mem_req_calc", 16'(mem_req), 16'd0);
        tick();
        check("ldi mem_req_p1", 16'(mem_req), 16'd1);
        check("ldi mem_addr_p1", mem_addr, 16'h4002);
        tick();
        check("ldi mem_req_p2", 16'(mem_req), 16'd1);
        check("ldi ea_valid_p2", 16'(ea_valid), 16'd0);
        tick();
        check("ldi mem_addr_p3", mem_addr, 16'h4002);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        check("ldi mem_req_p3", 16'(mem_req), 16'd1);
        tick();
        mem_ack = 1'b0; mem_rdata = 16'hFFFF;
        check("ldi mem_req_done", 16'(mem_req), 16'd0);
        pop_check("ldi");
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("ldi hold%0d ea_valid", k), 16'(ea_valid), 16'd1);
            check($sformatf("ldi hold%0d ea", k), ea, 16'h1234);
            check($sformatf("ldi hold%0d kind", k), 16'(kind), 16'(KIND_LOAD));
        end
        release_done("ldi");

        // STI whose pointer address wraps, ack in the first PTR cycle.
        offer("sti", 16'hB1FF, 16'h0000, 16'h0000);
        push_exp(16'h0ABC, 16'h0000, KIND_STORE, 1'b0);
        tick();
        check("sti mem_addr", mem_addr, 16'hFFFF);
        mem_ack = 1'b1; mem_rdata = 16'h0ABC;
        tick();
        mem_ack = 1'b0;
        pop_check("sti");
        release_done("sti");

        // LDI that is never acknowledged.
        offer("tmo", 16'hA010, 16'h1000, 16'h0000);
        push_exp(16'h0000, 16'h0000, KIND_LOAD, 1'b1);
        tick();
        check("tmo mem_addr", mem_addr, 16'h1010);
        n = 0; n_req = 0;
        while (!ea_valid && n < 20) begin
            n_req += int'(mem_req);
            tick();
            n++;
        end
        check("tmo mem_req_cycles", 16'(n_req), 16'(TO));
        pop_check("tmo");
        release_done("tmo");

        // Reset while a pointer fetch is outstanding.
        offer("rstptr", 16'hA000, 16'h2000, 16'h0000);
        tick();
        check("rstptr mem_req_before", 16'(mem_req), 16'd1);
        Reset = 1'b1;
        tick();
        check("rstptr mem_req", 16'(mem_req), 16'd0);
        check("rstptr ea_valid", 16'(ea_valid), 16'd0);
        check("rstptr ir_ready", 16'(ir_ready), 16'd1);
        check("rstptr ea", ea, 16'h0000);
        check("rstptr kind", 16'(kind), 16'd0);
        Reset = 1'b0;
        tick();
        check("rstptr ir_ready_after", 16'(ir_ready), 16'd1);
        run_vec(vt[1], 15);

        check("scoreboard_drained", 16'(sb_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
